// File: rtl/cla_word_sequencer.sv
// Multi-nibble adder controller: drives one registered 4-bit CLA slice one nibble
// at a time, LSB first, and chains each nibble's carry into the next.
module cla_word_sequencer #(
  parameter int W         = 16,
  parameter int SLICE_LAT = 3
) (
  input  logic         clk,
  input  logic         res,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic [3:0]   slice_x,
  output logic [3:0]   slice_y,
  output logic         slice_cin,
  input  logic [3:0]   slice_z,
  input  logic         slice_cout
);
  localparam int NIB = W / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW  = (SLICE_LAT > 1) ? $clog2(SLICE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            cout_q, rdy_q, vld_q, busy_q;
  logic [3:0]      sx_q, sy_q;
  logic            scin_q;

  // a_q/b_q hold the not-yet-issued nibbles, shifted down as each nibble is issued.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      scin_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (start_valid && rdy_q) begin
            a_q     <= a >> 4;
            b_q     <= b >> 4;
            sx_q    <= a[3:0];
            sy_q    <= b[3:0];
            scin_q  <= cin;
            k_q     <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= CW'(SLICE_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            for (int i = 0; i < NIB; i++)
              if (k_q == KW'(i)) sum_q[4*i +: 4] <= slice_z;
            if (k_q == KW'(NIB - 1)) begin
              cout_q  <= slice_cout;
              sx_q    <= '0;
              sy_q    <= '0;
              scin_q  <= 1'b0;
              vld_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              // next nibble's inputs go out on the same edge that captures this one
              k_q     <= k_q + 1'b1;
              sx_q    <= a_q[3:0];
              sy_q    <= b_q[3:0];
              scin_q  <= slice_cout;
              a_q     <= a_q >> 4;
              b_q     <= b_q >> 4;
              state_q <= ISSUE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = rdy_q;
  assign res_valid   = vld_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign busy        = busy_q;
  assign slice_x     = sx_q;
  assign slice_y     = sy_q;
  assign slice_cin   = scin_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench: two sequencer instances (16b/lat3 and 8b/lat1), each driving a
// behavioural registered 4-bit adder slice with the matching latency.
module tb_cla_word_sequencer;
  localparam int L0 = 3;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  // instance 0: W=16, SLICE_LAT=3
  logic        sv0, sr0, cin0, rv0, rr0, co0, busy0, scin0, scout0;
  logic [15:0] a0, b0, sum0;
  logic [3:0]  sx0, sy0, sz0;
  logic [4:0]  p0 [L0];

  cla_word_sequencer #(.W(16), .SLICE_LAT(L0)) dut0 (
    .clk(clk), .res(res), .start_valid(sv0), .start_ready(sr0),
    .a(a0), .b(b0), .cin(cin0), .res_valid(rv0), .res_ready(rr0),
    .sum(sum0), .cout(co0), .busy(busy0), .slice_x(sx0), .slice_y(sy0),
    .slice_cin(scin0), .slice_z(sz0), .slice_cout(scout0));

  always @(posedge clk) begin
    p0[0] <= {1'b0, sx0} + {1'b0, sy0} + {4'd0, scin0};
    for (int i = 1; i < L0; i++) p0[i] <= p0[i-1];
  end
  assign sz0    = p0[L0-1][3:0];
  assign scout0 = p0[L0-1][4];

  // instance 1: W=8, SLICE_LAT=1
  logic       sv1, sr1, cin1, rv1, rr1, co1, busy1, scin1, scout1;
  logic [7:0] a1, b1, sum1;
  logic [3:0] sx1, sy1, sz1;
  logic [4:0] p1 [L1];

  cla_word_sequencer #(.W(8), .SLICE_LAT(L1)) dut1 (
    .clk(clk), .res(res), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(cin1), .res_valid(rv1), .res_ready(rr1),
    .sum(sum1), .cout(co1), .busy(busy1), .slice_x(sx1), .slice_y(sy1),
    .slice_cin(scin1), .slice_z(sz1), .slice_cout(scout1));

  always @(posedge clk) begin
    p1[0] <= {1'b0, sx1} + {1'b0, sy1} + {4'd0, scin1};
  end
  assign sz1    = p1[0][3:0];
  assign scout1 = p1[0][4];

  int compared = 0;
  int mismatched = 0;
  int accepts0 = 0;

  always @(posedge clk) if (sv0 && sr0) accepts0 <= accepts0 + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic [3:0]  cs;   // slice_cin seen per nibble, bit j = nibble j
  } vec_t;

  vec_t tbl [5];

  // One operation on instance 0; hold>0 keeps res_ready low that many DONE cycles
  // and keeps start_valid high throughout to prove it is ignored.
  task automatic run_op(input vec_t v, input int hold);
    int n;
    int acc0;
    logic [15:0] xs;
    logic [3:0]  cs;
    xs = '0;
    cs = '0;
    @(negedge clk);
    a0 = v.a; b0 = v.b; cin0 = v.cin; sv0 = 1'b1;
    n = 0;
    while (!sr0 && n < 50) begin @(negedge clk); n++; end
    chk("start_ready before accept", {31'd0, sr0}, 32'd1);
    acc0 = accepts0;
    @(posedge clk);
    @(negedge clk);
    sv0 = (hold > 0);
    a0 = ~v.a; b0 = ~v.b; cin0 = ~v.cin;
    n = 0;
    while (!rv0 && n < 100) begin
      if ((n % (L0 + 1)) == 0 && (n / (L0 + 1)) < 4) begin
        xs[4*(n/(L0+1)) +: 4] = sx0;
        cs[n/(L0+1)] = scin0;
      end
      if (hold > 0 && sr0 !== 1'b0) chk("start_ready during op", {31'd0, sr0}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd16);
    chk("sum", {16'd0, sum0}, {16'd0, v.s});
    chk("cout", {31'd0, co0}, {31'd0, v.co});
    chk("slice_x sequence", {16'd0, xs}, {16'd0, v.a});
    chk("slice_cin sequence", {28'd0, cs}, {28'd0, v.cs});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("held valid/sum/cout/ready", {13'd0, rv0, co0, sr0, sum0},
            {13'd0, 1'b1, v.co, 1'b0, v.s});
      end
      chk("single accept", accepts0, acc0 + 1);
    end
    rr0 = 1'b1;
    @(negedge clk);
    rr0 = 1'b0;
    sv0 = 1'b0;
    chk("post handoff valid/busy/ready", {29'd0, rv0, busy0, sr0}, 32'b001);
  endtask

  initial begin
    int n;
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 4'b1110};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000};
    tbl[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 4'b0000};

    res = 1'b1;
    sv0 = 0; rr0 = 0; a0 = 0; b0 = 0; cin0 = 0;
    sv1 = 0; rr1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {sr0, rv0, co0, busy0, scin0, sx0, sy0, sum0},
        32'd0);
    res = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle after reset", {29'd0, sr0, busy0, rv0}, 32'b100);

    for (int i = 0; i < 4; i++) run_op(tbl[i], 0);

    run_op(tbl[0], 5);

    // reset during the WAIT of nibble 2 abandons the op
    @(negedge clk);
    a0 = 16'h1234; b0 = 16'h0FFF; cin0 = 1'b0; sv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy before reset", {31'd0, busy0}, 32'd1);
    res = 1'b1;
    #1;
    chk("async reset outputs", {sr0, rv0, co0, busy0, scin0, sx0, sy0, sum0},
        32'd0);
    @(negedge clk);
    chk("ready low in reset", {31'd0, sr0}, 32'd0);
    res = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle after mid-op reset", {29'd0, sr0, busy0, rv0}, 32'b100);
    run_op(tbl[4], 0);

    // W=8, SLICE_LAT=1
    @(negedge clk);
    a1 = 8'hF7; b1 = 8'h19; cin1 = 1'b1; sv1 = 1'b1;
    n = 0;
    while (!sr1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    sv1 = 1'b0;
    n = 0;
    while (!rv1 && n < 50) begin @(negedge clk); n++; end
    chk("w8 latency", n, 32'd4);
    chk("w8 sum", {24'd0, sum1}, 32'h11);
    chk("w8 cout", {31'd0, co1}, 32'd1);
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    chk("w8 valid drop", {30'd0, rv1, sr1}, 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
